// File: rtl/rinstr_encoder_pkg.sv
// Shared R-type encoding definitions: ALU op codes, func codes and field positions.
// Used by both the encoder and the existing R-type decoder.
package rinstr_encoder_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_NOR  = 3'b011,
        ALU_ADD  = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLLV = 3'b111
    } alu_op_e;

    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;
    localparam logic [5:0] FUNC_SLLV = 6'b000100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_MSB  = 5;
    localparam int FUNC_LSB  = 0;

    function automatic logic [5:0] alu_to_func(input logic [2:0] op);
        logic [5:0] f;
        case (alu_op_e'(op))
            ALU_ADD:  f = FUNC_ADD;
            ALU_SUB:  f = FUNC_SUB;
            ALU_AND:  f = FUNC_AND;
            ALU_OR:   f = FUNC_OR;
            ALU_XOR:  f = FUNC_XOR;
            ALU_NOR:  f = FUNC_NOR;
            ALU_SLTU: f = FUNC_SLTU;
            default:  f = FUNC_SLLV;
        endcase
        return f;
    endfunction

    // Inverse mapping for the decoder side; valid is low for func codes outside the table.
    function automatic logic [3:0] func_to_alu(input logic [5:0] func);
        logic [3:0] r;
        case (func)
            FUNC_ADD:  r = {1'b1, ALU_ADD};
            FUNC_SUB:  r = {1'b1, ALU_SUB};
            FUNC_AND:  r = {1'b1, ALU_AND};
            FUNC_OR:   r = {1'b1, ALU_OR};
            FUNC_XOR:  r = {1'b1, ALU_XOR};
            FUNC_NOR:  r = {1'b1, ALU_NOR};
            FUNC_SLTU: r = {1'b1, ALU_SLTU};
            FUNC_SLLV: r = {1'b1, ALU_SLLV};
            default:   r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] encode_rtype(
        input logic [2:0] op,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [31:0] w;
        w = '0;
        w[OP_MSB:OP_LSB]       = OP_RTYPE;
        w[RS_MSB:RS_LSB]       = rs;
        w[RT_MSB:RT_LSB]       = rt;
        w[RD_MSB:RD_LSB]       = rd;
        w[SHAMT_MSB:SHAMT_LSB] = 5'b00000;
        w[FUNC_MSB:FUNC_LSB]   = alu_to_func(op);
        return w;
    endfunction

endpackage

// File: rtl/rinstr_encoder_sync_fifo.sv
// Synchronous FIFO with synchronous flush; head entry and status come straight from registers.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    // Gate the head with empty so a drained or reset FIFO presents zero data.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PW'(1);
            if (pop_ok)  rptr_d = rptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rinstr_encoder.sv
// Builds MIPS R-type words from ALU commands, buffers them and writes them
// sequentially into instruction memory through a ready-gated port.
module rinstr_encoder
    import rinstr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_alu_op,
    input  logic [4:0]              in_rs,
    input  logic [4:0]              in_rt,
    input  logic [4:0]              in_rd,
    output logic                    im_we,
    input  logic                    im_ready,
    output logic [ADDR_W-1:0]       im_addr,
    output logic [31:0]             im_wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    wrap
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rinstr_encoder: DEPTH must be a power of two and at least 2");
    end

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       enc_word;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;

    assign enc_word = encode_rtype(in_alu_op, in_rs, in_rt, in_rd);

    assign in_ready = !fifo_full;
    assign im_we    = !fifo_empty;
    assign push     = in_valid && in_ready && !clr;
    assign pop      = im_we && im_ready && !clr;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clr),
        .push_i  (push),
        .wdata_i (enc_word),
        .pop_i   (pop),
        .rdata_o (im_wdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        addr_d = addr_q;
        wrap_d = wrap_q;
        if (clr) begin
            addr_d = BASE;
            wrap_d = 1'b0;
        end else if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            if (&addr_q) wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE;
            wrap_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= wrap_d;
        end
    end

    assign im_addr = addr_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_rinstr_encoder.sv
// Self-checking bench for rinstr_encoder: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rinstr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;
    localparam int BASE   = 0;
    localparam int NADDR  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_alu_op = '0;
    logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0;
    logic              im_we;
    logic              im_ready = 1'b0;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [2:0]        count;
    logic              wrap;

    rinstr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of pending words, a write address and the sticky wrap bit.
    logic [31:0] mq[$];
    int          maddr = BASE;
    bit          mwrap = 1'b0;
    int          func_tab [8] = '{32'h24, 32'h25, 32'h26, 32'h27, 32'h20, 32'h22, 32'h2B, 32'h04};

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] ref_word(int op, int rs, int rt, int rd);
        return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + func_tab[op]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        maddr = BASE;
        mwrap = 1'b0;
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("im_we", 32'(im_we), 32'(mq.size() > 0));
        chk("im_addr", 32'(im_addr), 32'(maddr));
        chk("wrap", 32'(wrap), 32'(mwrap));
        if (mq.size() > 0) chk("im_wdata", im_wdata, mq[0]);
    endtask

    // Check the current outputs, advance the model by the inputs now driven, move to next negedge.
    task automatic step();
        bit do_push, do_pop;
        check_state();
        if (clr) begin
            model_reset();
        end else begin
            do_pop  = (mq.size() > 0) && im_ready;
            do_push = in_valid && (mq.size() < DEPTH);
            if (do_pop) begin
                void'(mq.pop_front());
                if (maddr == NADDR - 1) mwrap = 1'b1;
                maddr = (maddr + 1) % NADDR;
            end
            if (do_push) mq.push_back(ref_word(int'(in_alu_op), int'(in_rs), int'(in_rt), int'(in_rd)));
        end
        @(negedge clk);
    endtask

    task automatic drive_rand_cmd();
        in_alu_op = 3'($urandom);
        in_rs     = 5'($urandom);
        in_rt     = 5'($urandom);
        in_rd     = 5'($urandom);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        im_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (mq.size() == 0) break;
            step();
        end
        chk("drain_we", 32'(im_we), 32'(0));
    endtask

    initial begin
        bit accepted;

        vecs.push_back('{3'd4, 5'd1,  5'd2,  5'd3,  32'h00221820});
        vecs.push_back('{3'd4, 5'd0,  5'd0,  5'd0,  32'h00000020});
        vecs.push_back('{3'd5, 5'd0,  5'd0,  5'd0,  32'h00000022});
        vecs.push_back('{3'd0, 5'd0,  5'd0,  5'd0,  32'h00000024});
        vecs.push_back('{3'd1, 5'd0,  5'd0,  5'd0,  32'h00000025});
        vecs.push_back('{3'd2, 5'd0,  5'd0,  5'd0,  32'h00000026});
        vecs.push_back('{3'd3, 5'd0,  5'd0,  5'd0,  32'h00000027});
        vecs.push_back('{3'd6, 5'd0,  5'd0,  5'd0,  32'h0000002B});
        vecs.push_back('{3'd7, 5'd0,  5'd0,  5'd0,  32'h00000004});
        vecs.push_back('{3'd7, 5'd31, 5'd31, 5'd31, 32'h03FFF804});
        vecs.push_back('{3'd6, 5'd5,  5'd10, 5'd17, 32'h00AA882B});

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst_we", 32'(im_we), 32'(0));
        chk("rst_wdata", im_wdata, 32'h0);
        chk("rst_addr", 32'(im_addr), 32'(BASE));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_wrap", 32'(wrap), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Vector table, back-to-back with memory always ready
        im_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid  = 1'b1;
            in_alu_op = vecs[i].op;
            in_rs     = vecs[i].rs;
            in_rt     = vecs[i].rt;
            in_rd     = vecs[i].rd;
            step();
            chk("vec_we", 32'(im_we), 32'(1));
            chk("vec_wdata", im_wdata, vecs[i].word);
            chk("vec_addr", 32'(im_addr), 32'(i));
        end
        drain();

        // Backpressure: five commands while memory stalls
        im_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand_cmd();
            step();
        end
        chk("bp_count", 32'(count), 32'(4));
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        drive_rand_cmd();
        step();
        step();
        chk("bp_count_hold", 32'(count), 32'(4));
        im_ready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            accepted = in_ready;
            step();
            if (accepted) break;
        end
        chk("bp_fifth_accepted", 32'(accepted), 32'(1));
        drain();

        // Address wrap after 64 pops
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b1;
        im_ready = 1'b1;
        for (int i = 0; i < NADDR; i++) begin
            drive_rand_cmd();
            step();
        end
        chk("wrap_addr63", 32'(im_addr), 32'(NADDR - 1));
        chk("wrap_pre", 32'(wrap), 32'(0));
        drain();
        chk("wrap_addr0", 32'(im_addr), 32'(0));
        chk("wrap_set", 32'(wrap), 32'(1));

        // clr with three entries queued and a simultaneous push
        im_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand_cmd();
            step();
        end
        chk("clr_pre_count", 32'(count), 32'(3));
        clr = 1'b1;
        im_ready = 1'b1;
        drive_rand_cmd();
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", 32'(count), 32'(0));
        chk("clr_we", 32'(im_we), 32'(0));
        chk("clr_addr", 32'(im_addr), 32'(BASE));
        chk("clr_wrap", 32'(wrap), 32'(0));
        chk("clr_in_ready", 32'(in_ready), 32'(1));

        // Asynchronous reset mid-stream
        im_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_rand_cmd();
            step();
        end
        in_valid = 1'b0;
        step();
        chk("arst_pre_we", 32'(im_we), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(im_we), 32'(0));
        chk("arst_count", 32'(count), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        im_ready = 1'b1;
        in_valid = 1'b1;
        drive_rand_cmd();
        step();
        in_valid = 1'b0;
        chk("arst_next_addr", 32'(im_addr), 32'(BASE));
        chk("arst_next_we", 32'(im_we), 32'(1));
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom);
            im_ready = ($urandom_range(3) != 0);
            clr      = ($urandom_range(40) == 0);
            drive_rand_cmd();
            step();
        end
        clr = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rinstr_encoder.md
Name: rinstr_encoder

Overview:
- Inverse of the R-type opcode/func decoder: takes an ALU operation plus register fields and builds the 32-bit MIPS R-type instruction word.
- Encoded words are buffered in a small FIFO, then written sequentially into instruction memory through a ready-gated write port.
- Sits between the test/boot program generator and the instruction memory.
- A decoder fed the stored words must reproduce WE=1 and the original ALU_OP.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 6, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after reset or clear.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: flush FIFO, reload address counter.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept a command.
- in_alu_op  in  3  ALU operation code.
- in_rs  in  5  source register 1.
- in_rt  in  5  source register 2.
- in_rd  in  5  destination register.
- im_we  out  1  instruction-memory write strobe.
- im_ready  in  1  memory accepts the write this cycle.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded instruction.
- count  out  clog2(DEPTH)+1  FIFO occupancy.
- wrap  out  1  sticky flag: address counter wrapped past all-ones.

Behaviour:
- Encoding (combinational, at FIFO input): word = {6'b000000, rs, rt, rd, 5'b00000, func}.
- alu_op to func mapping (total; every alu_op is legal):
  - 100 -> 100000 (add)
  - 101 -> 100010 (sub)
  - 000 -> 100100 (and)
  - 001 -> 100101 (or)
  - 010 -> 100110 (xor)
  - 011 -> 100111 (nor)
  - 110 -> 101011 (sltu)
  - 111 -> 000100 (sllv)
- Input handshake:
  - Push when in_valid && in_ready.
  - in_ready = !full; it does not depend on in_valid.
- Output handshake:
  - im_we = !empty; im_wdata = head entry; im_addr = address counter. All registered or derived from registers only.
  - Pop and address increment occur when im_we && im_ready.
  - im_we/im_wdata/im_addr must hold stable while im_ready is low.
- Latency: a word pushed in cycle N gives im_we=1 in cycle N+1 at the earliest. There is no combinational in-to-out path.
- Simultaneous push and pop:
  - Allowed when full: in_ready stays 0 when full, so no push occurs.
  - Allowed when empty: the push lands and im_we rises next cycle; no bypass.
  - Otherwise count is unchanged.
- Pointers: log2(DEPTH)-bit read and write pointers wrap naturally; count ranges 0..DEPTH.
- Address counter:
  - ADDR_W bits, increments by 1 per pop, wraps from all-ones to 0.
  - wrap sets on that transition and stays set until reset or clr.
- clr:
  - Empties the FIFO, sets the address counter to BASE_ADDR, clears wrap.
  - Drops any push or pop in the same cycle.
  - in_ready=1 and im_we=0 in the following cycle.
- Reset (async assert, sync-safe deassert): im_we=0, im_wdata=0, im_addr=BASE_ADDR, count=0, wrap=0, in_ready=1.
- Reset mid-transfer: the pending word is discarded; no partial write is ever seen.

Decomposition:
- Shared package holds:
  - ALU_OP constants: AND=000, OR=001, XOR=010, NOR=011, ADD=100, SUB=101, SLTU=110, SLLV=111.
  - func constants.
  - OP_RTYPE=6'b000000.
  - Field position constants: rs 25:21, rt 20:16, rd 15:11, shamt 10:6, func 5:0.
- The existing decoder reuses this package.
- One natural sub-module: sync_fifo (parameters WIDTH=32, DEPTH), providing push/pop/full/empty/count and flush.

Test Plan:
- Reset, then one command alu_op=100, rs=1, rt=2, rd=3, im_ready=1 -> one cycle later im_we=1, im_addr=0, im_wdata=32'h00221820.
- All 8 alu_op values back-to-back, rs=rt=rd=0, im_ready=1 -> addresses 0..7 with func 20,22,24,25,26,27,2B,04 (hex) in push order.
- im_ready=0 while pushing 5 commands (DEPTH=4) -> in_ready=0 after the 4th push, count=4, outputs stable; raise im_ready -> 4 writes, then the 5th command is accepted.
- 64 pops with ADDR_W=6 -> im_addr reaches 63, then 0; wrap=1 afterwards.
- clr asserted with count=3 and a simultaneous push -> next cycle count=0, im_we=0, im_addr=BASE_ADDR, wrap=0.
- rst_n pulsed low mid-stream with im_ready=0 -> im_we falls immediately (asynchronously) and count=0; the next push writes to BASE_ADDR.
